// File: rtl/pipelined_addsub_pkg.sv
// Shared sizing helpers and mode encodings for the carry-pipelined add/sub core.
package pipelined_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of every segment except the last one (ceil(width/stages)).
    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Width left over for the most significant segment; may be <= 0 for
    // parameter pairs that cannot be split evenly enough.
    function automatic int last_seg_width(input int width, input int stages);
        return width - (stages - 1) * seg_width(width, stages);
    endfunction

endpackage

// File: rtl/pipelined_addsub_segment.sv
// One registered carry-pipeline segment: adds its slice, forwards the carry,
// delays the not-yet-used operand bits and extends the low result bits.
module addsub_segment
    import pipelined_addsub_pkg::*;
#(
    parameter int SEG_W  = 1,
    parameter int LOW_W  = 0,
    parameter int HIGH_W = 0,
    localparam int LOW_PW  = (LOW_W > 0) ? LOW_W : 1,
    localparam int HIGH_PW = (HIGH_W > 0) ? HIGH_W : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      valid_in,
    input  logic                      cin,
    input  logic                      sub_in,
    input  logic [SEG_W+HIGH_W-1:0]   a_rem,
    input  logic [SEG_W+HIGH_W-1:0]   b_rem,
    input  logic [LOW_PW-1:0]         low_in,
    output logic                      valid_q,
    output logic                      cout_q,
    output logic                      ext_q,
    output logic                      sub_q,
    output logic [HIGH_PW-1:0]        a_hi_q,
    output logic [HIGH_PW-1:0]        b_hi_q,
    output logic [LOW_W+SEG_W-1:0]    sum_q
);

    logic [SEG_W:0]             part;
    logic [LOW_W+SEG_W-1:0]     sum_new;
    logic                       valid_d;
    logic                       cout_d;
    logic                       ext_d;
    logic                       sub_d;
    logic [LOW_W+SEG_W-1:0]     sum_d;

    assign part = {1'b0, a_rem[SEG_W-1:0]} + {1'b0, b_rem[SEG_W-1:0]}
                + {{SEG_W{1'b0}}, cin};

    if (LOW_W > 0) begin : g_low
        assign sum_new = {part[SEG_W-1:0], low_in};
    end else begin : g_nolow
        logic unused_low;
        assign sum_new    = part[SEG_W-1:0];
        assign unused_low = ^low_in;
    end

    // Next-state: load the new slice result when the pipeline advances.
    // ext is the top result bit as seen by the user: carry for add, borrow
    // (inverted carry) for subtract; only the last segment's copy is used.
    always_comb begin
        valid_d = valid_q;
        cout_d  = cout_q;
        ext_d   = ext_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        if (enable) begin
            valid_d = valid_in;
            cout_d  = part[SEG_W];
            ext_d   = (sub_in == MODE_ADD) ? part[SEG_W] : ~part[SEG_W];
            sub_d   = sub_in;
            sum_d   = sum_new;
        end
    end

    // Control and result flops are reset so a cleared pipe shows no output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            ext_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cout_q  <= cout_d;
            ext_q   <= ext_d;
            sum_q   <= sum_d;
        end
    end

    // Mode flag travels with the data; no reset needed.
    always_ff @(posedge clk) begin
        sub_q <= sub_d;
    end

    if (HIGH_W > 0) begin : g_high
        logic [HIGH_PW-1:0] a_hi_d;
        logic [HIGH_PW-1:0] b_hi_d;

        // Hold or advance the operand bits still waiting for their segment.
        always_comb begin
            a_hi_d = a_hi_q;
            b_hi_d = b_hi_q;
            if (enable) begin
                a_hi_d = a_rem[SEG_W+HIGH_W-1:SEG_W];
                b_hi_d = b_rem[SEG_W+HIGH_W-1:SEG_W];
            end
        end

        // Operand delay line, data only.
        always_ff @(posedge clk) begin
            a_hi_q <= a_hi_d;
            b_hi_q <= b_hi_d;
        end
    end else begin : g_nohigh
        assign a_hi_q = '0;
        assign b_hi_q = '0;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Unsigned WIDTH-bit add/subtract, split into STAGES carry-pipelined
// segments behind an input register, with valid/ready flow control.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 122,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int SEG    = seg_width(WIDTH, STAGES);
    localparam int LAST_W = last_seg_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || LAST_W < 1) begin : g_bad_cfg
        $fatal(1, "pipelined_addsub: WIDTH/STAGES leave no bits for the last segment");
    end

    logic               stall;
    logic [STAGES-1:0]  seg_valid;

    logic               v0_q, v0_d;
    logic [WIDTH-1:0]   a0_q, a0_d;
    logic [WIDTH-1:0]   b0_q, b0_d;
    logic               cin0_q, cin0_d;
    logic               sub0_q, sub0_d;

    // A result sitting at the output that nobody takes freezes everything.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & rst_n;
    assign busy     = v0_q | (|seg_valid);

    // Input stage: subtraction is a + ~b + 1, so invert b and set the carry-in.
    always_comb begin
        v0_d   = v0_q;
        a0_d   = a0_q;
        b0_d   = b0_q;
        cin0_d = cin0_q;
        sub0_d = sub0_q;
        if (!stall) begin
            v0_d   = in_valid & in_ready;
            a0_d   = a;
            b0_d   = b ^ {WIDTH{in_sub}};
            cin0_d = (in_sub == MODE_SUB);
            sub0_d = in_sub;
        end
    end

    // Input stage valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
        end else begin
            v0_q <= v0_d;
        end
    end

    // Input stage operands, data only.
    always_ff @(posedge clk) begin
        a0_q   <= a0_d;
        b0_q   <= b0_d;
        cin0_q <= cin0_d;
        sub0_q <= sub0_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        localparam int SW  = (k == STAGES - 1) ? LAST_W : SEG;
        localparam int LW  = k * SEG;
        localparam int RW  = WIDTH - k * SEG;
        localparam int HW  = RW - SW;
        localparam int HPW = (HW > 0) ? HW : 1;
        localparam int LPW = (LW > 0) ? LW : 1;

        logic [RW-1:0]      a_rem;
        logic [RW-1:0]      b_rem;
        logic [LPW-1:0]     low_in;
        logic               v_in;
        logic               cin_in;
        logic               sub_in;
        logic               vld;
        logic               cout;
        logic               ext;
        logic               sub_o;
        logic [HPW-1:0]     a_hi;
        logic [HPW-1:0]     b_hi;
        logic [LW+SW-1:0]   sum_lo;

        if (k == 0) begin : g_first
            assign a_rem  = a0_q;
            assign b_rem  = b0_q;
            assign low_in = '0;
            assign v_in   = v0_q;
            assign cin_in = cin0_q;
            assign sub_in = sub0_q;
        end else begin : g_chain
            assign a_rem  = g_seg[k-1].a_hi;
            assign b_rem  = g_seg[k-1].b_hi;
            assign low_in = g_seg[k-1].sum_lo;
            assign v_in   = g_seg[k-1].vld;
            assign cin_in = g_seg[k-1].cout;
            assign sub_in = g_seg[k-1].sub_o;
        end

        addsub_segment #(
            .SEG_W  (SW),
            .LOW_W  (LW),
            .HIGH_W (HW)
        ) u_seg (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable   (~stall),
            .valid_in (v_in),
            .cin      (cin_in),
            .sub_in   (sub_in),
            .a_rem    (a_rem),
            .b_rem    (b_rem),
            .low_in   (low_in),
            .valid_q  (vld),
            .cout_q   (cout),
            .ext_q    (ext),
            .sub_q    (sub_o),
            .a_hi_q   (a_hi),
            .b_hi_q   (b_hi),
            .sum_q    (sum_lo)
        );

        assign seg_valid[k] = vld;

        if (k == STAGES - 1) begin : g_out
            logic unused_tail;
            assign out_valid   = vld;
            assign sum         = {ext, sum_lo};
            assign unused_tail = ^{cout, sub_o, a_hi, b_hi};
        end else begin : g_mid
            logic unused_ext;
            assign unused_ext = ext;
        end
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the fixed-width registered adder benchmark.
- Performs unsigned add or subtract on WIDTH-bit operands, split into STAGES carry-pipelined segments.
- Carries a per-transaction valid/ready handshake with backpressure.
- Used as a scalable arithmetic benchmark core and as a reusable datapath block.

Parameters:
- WIDTH, 122, operand width in bits; legal range is 1 or more.
- STAGES, 4, number of carry-pipeline segments; legal range is 1 to WIDTH.
- SEG (localparam), ceil(WIDTH/STAGES), segment width. The last segment is WIDTH-(STAGES-1)*SEG bits; if that is not positive, elaboration fails via an assertion.

Ports:
- clk  in  1  single clock, all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block can accept this cycle
- in_sub  in  1  0 = add, 1 = subtract (a-b)
- a  in  WIDTH  operand a
- b  in  WIDTH  operand b
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH+1  result; bit WIDTH is carry (add) or borrow (sub)
- busy  out  1  any pipeline stage holds a valid transaction

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all stage valid bits, out_valid, busy and sum are 0 and in_ready is 0. Data registers other than sum need no reset. in_ready rises in the first cycle after rst_n deasserts.
- Reset asserted mid-operation discards every in-flight transaction immediately, with no partial output.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall & rst_n.
  - When stall=1, every stage register holds its value (global enable).
  - When stall=0, all stages advance.
- Accept: a transfer occurs when in_valid & in_ready.
  - Stage 0 captures a, b ^ {WIDTH{in_sub}}, cin = in_sub, and the sub flag.
  - Stage 0 valid = in_valid & in_ready.
- Segment k (k = 0..STAGES-1) registers:
  - its SEG-bit partial sum, using the carry from segment k-1 (cin for k=0);
  - its carry-out;
  - the remaining higher operand bits, delayed one stage;
  - the lower sum bits already produced.
- The final stage drives sum and out_valid directly from registers.
- Latency is STAGES+1 cycles from accept to out_valid, absent stalls.
- Throughput is one result per cycle when out_ready is held at 1.
- Bubbles (in_valid=0) propagate as valid=0. out_valid=0 while a bubble sits in the last stage, even though the sum register may hold stale data.
- Result encoding:
  - Add: sum = a + b, full WIDTH+1 bits.
  - Sub: sum[WIDTH-1:0] = (a - b) mod 2^WIDTH; sum[WIDTH] = 1 iff a < b unsigned (borrow = ~carry-out).
- Ordering: results leave in acceptance order. No reordering, no drop.
- Simultaneous out_valid & out_ready & in_valid: the output is consumed, the pipeline advances, and the new input is accepted in the same cycle.
- busy = OR of all stage valid bits, including out_valid.
- STAGES=1 degenerates to an input register plus one full-width adder register (latency 2). This is equivalent to the original benchmark with a handshake added.

Decomposition:
- Package pipelined_addsub_pkg holds:
  - function seg_width(WIDTH, STAGES);
  - function last_seg_width;
  - localparams MODE_ADD=1'b0 and MODE_SUB=1'b1.
- Sub-module addsub_segment: one registered segment.
  - Parameters: SEG_W, LOW_W, HIGH_W.
  - Inputs: enable, valid_in, cin, operand slices, passthrough bits, sub flag.
  - Outputs: the registered equivalents.
  - Instantiated STAGES times in a generate loop.
  - The top level contains only stage 0, the stall logic and the output mapping.

Test Plan:
- Carry ripple across all segments (WIDTH=122, STAGES=4): add a=2^122-1, b=1 -> after 5 cycles out_valid=1, sum=2^122 (bit 122 = 1, all others 0).
- Subtract with borrow: sub a=0, b=1 -> sum[121:0]=all ones, sum[122]=1. Then sub a=5, b=3 -> sum=2, sum[122]=0.
- Back-to-back: 20 random add/sub transactions on consecutive cycles with out_ready=1 -> 20 consecutive out_valid cycles starting cycle 6, matching a reference model in order.
- Backpressure: hold out_ready=0 for 7 cycles while driving in_valid=1 -> in_ready=0 once out_valid=1. No result is lost or duplicated; the sum value is stable during the stall; the sequence matches the model after release.
- Reset mid-flight: assert rst_n=0 with 3 transactions in flight -> out_valid, busy and sum are 0 asynchronously. After release no stale result appears, and the first new result arrives exactly 5 cycles after its accept.
- Config sweep: WIDTH=7, STAGES=3 (SEG=3, last=1) and WIDTH=8, STAGES=1 -> exhaustive or random add/sub checks pass, with latency STAGES+1.
